idct_8x8_serial: RTL and testbench
==================================

# idct_8x8_serial

Sequential 8x8 inverse DCT engine, the decode-side counterpart of the DCT coefficient path. It accepts one 64-coefficient block over a valid/ready stream and reconstructs it with a separable row/column transform on a single shared MAC. It uses the same Q8 cosine constants as the forward DCT LUTs, and drains 64 reconstructed pixels over a second valid/ready stream. It sits between the coefficient dequantiser and the pixel output buffer.

## Interface
- COEF_W, 16, signed coefficient width (only default is supported)
- PIX_W, 16, output pixel width (only default is supported)
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  coefficient valid
- in_ready  out  1  engine accepts a coefficient
- in_coef  in  COEF_W  signed coefficient X[k1][k2], index k1*8+k2, k1 major
- out_valid  out  1  pixel valid
- out_ready  in  1  downstream accepts a pixel
- out_pixel  out  PIX_W  pixel x[n1][n2], index n1*8+n2, n1 major
- out_last  out  1  high with the 64th pixel of a block
- busy  out  1  high in PASS1, PASS2 and DRAIN

## Operation
- Clock and reset: one clock (clk); reset is asynchronous and active-low (rst_n).
- Basis constant B[k][n]:
  - For k=0: 181.
  - Otherwise: sign-folded Q8 cos(m·π/16), with m=((2n+1)k) mod 32.
  - Magnitudes for m=0..7: 256, 251, 236, 212, 181, 142, 97, 49, each cos·256 truncated.
  - Produced by an internal combinational table.
- States and transitions:
  - LOAD -> PASS1 after the 64th accepted coefficient.
  - PASS1 -> PASS2 -> DRAIN.
  - DRAIN -> LOAD after the 64th output handshake.
- LOAD:
  - in_ready=1.
  - Each in_valid&in_ready writes coef RAM[cnt] and increments cnt.
- PASS1, 512 cycles:
  - For each (k1,n2), accumulate X[k1][k2]·B[k2][n2] over k2=0..7, one product per cycle.
  - Accumulator is COEF_W+12 bits signed and is cleared on k2=0.
  - On k2=7, T[k1][n2]=(acc+128)>>>8 is written to the T RAM, COEF_W+4 bits.
- PASS2, 512 cycles:
  - For each (n1,n2), accumulate T[k1][n2]·B[k1][n1] over k1=0..7.
  - Accumulator is COEF_W+16 bits.
  - Result r=(acc+512)>>>10 is saturated to signed PIX_W and written to the pixel RAM.
- DRAIN:
  - out_pixel shows pixel RAM[ocnt].
  - ocnt advances on out_valid&out_ready.
  - out_valid and out_pixel are held stable while out_ready=0.
- Rounding is add-half then arithmetic shift, i.e. floor(x+0.5), including negatives.
- Reset at any point, including mid-pass:
  - State returns to LOAD and all counters and accumulators clear.
  - RAM contents are don't-care.
  - The partial block is discarded.

## Timing
- Reset values:
  - in_ready=1 (in LOAD).
  - out_valid=0, out_last=0, busy=0, out_pixel=0.
- Handshake: transfer occurs only on valid&ready in the same cycle. in_valid while in_ready=0 is ignored; the coefficient is neither consumed nor stored.
- in_ready drops the cycle after the 64th acceptance.
- busy rises the cycle after the 64th acceptance.
- PASS1 occupies exactly 512 cycles; PASS2 occupies exactly 512 cycles.
- The first out_valid occurs 1025 cycles after the cycle of the 64th input acceptance.
- With out_ready held high, 64 pixels leave in 64 consecutive cycles.
- out_last is high only while ocnt=63.
- The cycle after the final output handshake: out_valid=0, busy=0, in_ready=1.
- Throughput with no backpressure: one block per 64+1024+64 cycles. There is no overlap between blocks.

## Configuration
- IDCT_LEVEL_SHIFT_EN defined:
  - Pixel = r+128, clamped to 0..255, zero-extended to PIX_W.
  - Intended for 8-bit image reconstruction.
- IDCT_LEVEL_SHIFT_EN undefined: pixel = r saturated to -32768..32767.

## Test plan
- X[0][0]=1024, all others 0 -> all 64 pixels 128. With IDCT_LEVEL_SHIFT_EN, all 255 (256 clamped).
- All-zero block -> 64 pixels of 0, out_last on beat 64. With the macro, all 128.
- X[0][1]=256, others 0 -> every row n1 is 44, 37, 25, 9, -9, -25, -37, -44.
- All 64 coefficients 32767, macro undefined -> pixel[0] saturates to 32767.
- Backpressure:
  - Stimulus: X[0][0]=-1024; out_ready toggles 1,0,0,1 repeating; in_valid held high throughout DRAIN.
  - Required: each pixel is -128 (0 with the macro) and is held stable while stalled; exactly 64 transfers; in_ready stays 0 until DRAIN completes; no coefficient is taken early.
- Reset mid-operation:
  - Stimulus: assert rst_n=0 for 2 cycles at cycle 300 of PASS1.
  - Required: busy=0, out_valid=0, in_ready=1 immediately.
  - Required: a subsequent DC=1024 block yields all 128 at the nominal 1025-cycle latency.

Source files
------------

// File: rtl/idct_8x8_serial_if.sv
// Stream bundle for idct_8x8_serial: coefficient input stream and pixel output stream.
interface idct_8x8_serial_if #(
  parameter int COEF_W = 16,
  parameter int PIX_W  = 16
);
  logic                     in_valid;
  logic                     in_ready;
  logic signed [COEF_W-1:0] in_coef;
  logic                     out_valid;
  logic                     out_ready;
  logic        [PIX_W-1:0]  out_pixel;
  logic                     out_last;

  modport master (
    output in_valid, in_coef, out_ready,
    input  in_ready, out_valid, out_pixel, out_last
  );

  modport slave (
    input  in_valid, in_coef, out_ready,
    output in_ready, out_valid, out_pixel, out_last
  );
endinterface

// File: rtl/idct_8x8_serial.sv
// Sequential 8x8 inverse DCT: load 64 coefficients, row pass and column pass on one MAC, drain 64 pixels.
// Optional IDCT_LEVEL_SHIFT_EN: pixel = clamp(r+128, 0..255) instead of signed saturation.
module idct_8x8_serial #(
  parameter int COEF_W = 16,
  parameter int PIX_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  idct_8x8_serial_if.slave io,
  output logic             busy
);
  localparam int T_W   = COEF_W + 4;
  localparam int B_W   = 10;
  localparam int ACC_W = COEF_W + 16;

  localparam logic signed [ACC_W-1:0] RND1 = ACC_W'(128);
  localparam logic signed [ACC_W-1:0] RND2 = ACC_W'(512);
`ifndef IDCT_LEVEL_SHIFT_EN
  localparam logic signed [ACC_W-1:0] PIX_MAX = ACC_W'((1 << (PIX_W - 1)) - 1);
  localparam logic signed [ACC_W-1:0] PIX_MIN = -PIX_MAX - ACC_W'(1);
`endif

  typedef enum logic [1:0] {S_LOAD, S_PASS1, S_PASS2, S_DRAIN} state_t;

  state_t                   state_q, state_d;
  logic [8:0]               cnt_q, cnt_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic                     in_ready_q, in_ready_d;
  logic                     out_valid_q, out_valid_d;
  logic                     out_last_q, out_last_d;
  logic                     busy_q, busy_d;
  logic [PIX_W-1:0]         out_pixel_q, out_pixel_d;

  logic signed [COEF_W-1:0] coef_ram [64];
  logic signed [T_W-1:0]    t_ram    [64];
  logic [PIX_W-1:0]         pix_ram  [64];

  logic                     coef_we, t_we, pix_we;
  logic [2:0]               c_hi, c_mid, c_lo;
  logic signed [T_W-1:0]    op_a;
  logic signed [B_W-1:0]    op_b;
  logic signed [ACC_W-1:0]  prod, mac_sum, r;
  logic [T_W-1:0]           t_val;
  logic [PIX_W-1:0]         pix_val;
`ifdef IDCT_LEVEL_SHIFT_EN
  logic signed [ACC_W-1:0]  r_ls;
`endif

  // Q8 basis: k=0 row is 181, else sign-folded cos((2n+1)k*pi/16)*256, truncated.
  function automatic logic signed [B_W-1:0] basis(input logic [2:0] k, input logic [2:0] n);
    logic [4:0] m;
    logic [4:0] f;
    logic [4:0] g;
    logic [8:0] mag;
    logic       neg;
    m   = {1'b0, n, 1'b1} * {2'b00, k};
    f   = (m > 5'd16) ? 5'd0 - m : m;
    neg = (f > 5'd8);
    g   = neg ? 5'd16 - f : f;
    case (g)
      5'd0:    mag = 9'd256;
      5'd1:    mag = 9'd251;
      5'd2:    mag = 9'd236;
      5'd3:    mag = 9'd212;
      5'd4:    mag = 9'd181;
      5'd5:    mag = 9'd142;
      5'd6:    mag = 9'd97;
      5'd7:    mag = 9'd49;
      default: mag = 9'd0;
    endcase
    if (k == 3'd0) begin
      return B_W'(181);
    end
    return neg ? -$signed({1'b0, mag}) : $signed({1'b0, mag});
  endfunction

  assign c_hi  = cnt_q[8:6];
  assign c_mid = cnt_q[5:3];
  assign c_lo  = cnt_q[2:0];

  // Shared MAC: PASS1 walks X[k1][k2]*B[k2][n2], PASS2 walks T[k1][n2]*B[k1][n1]; c_lo is the summed index.
  always_comb begin
    if (state_q == S_PASS2) begin
      op_a = t_ram[{c_lo, c_mid}];
      op_b = basis(c_lo, c_hi);
    end else begin
      op_a = T_W'(coef_ram[{c_hi, c_lo}]);
      op_b = basis(c_lo, c_mid);
    end
    prod    = ACC_W'(op_a) * ACC_W'(op_b);
    mac_sum = ((c_lo == 3'd0) ? '0 : acc_q) + prod;
    t_val   = T_W'((mac_sum + RND1) >>> 8);
    r       = (mac_sum + RND2) >>> 10;
`ifdef IDCT_LEVEL_SHIFT_EN
    r_ls = r + ACC_W'(128);
    if (r_ls < 0) begin
      pix_val = '0;
    end else if (r_ls > 255) begin
      pix_val = PIX_W'(255);
    end else begin
      pix_val = PIX_W'(r_ls[7:0]);
    end
`else
    if (r > PIX_MAX) begin
      pix_val = PIX_W'(PIX_MAX);
    end else if (r < PIX_MIN) begin
      pix_val = PIX_W'(PIX_MIN);
    end else begin
      pix_val = PIX_W'(r);
    end
`endif
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    busy_d      = busy_q;
    out_pixel_d = out_pixel_q;
    coef_we     = 1'b0;
    t_we        = 1'b0;
    pix_we      = 1'b0;
    case (state_q)
      S_LOAD: begin
        if (io.in_valid && in_ready_q) begin
          coef_we = 1'b1;
          if (cnt_q[5:0] == 6'd63) begin
            state_d    = S_PASS1;
            cnt_d      = '0;
            in_ready_d = 1'b0;
            busy_d     = 1'b1;
          end else begin
            cnt_d = cnt_q + 9'd1;
          end
        end
      end
      S_PASS1: begin
        acc_d = mac_sum;
        t_we  = (c_lo == 3'd7);
        cnt_d = cnt_q + 9'd1;
        if (cnt_q == 9'd511) begin
          state_d = S_PASS2;
          acc_d   = '0;
        end
      end
      S_PASS2: begin
        acc_d  = mac_sum;
        pix_we = (c_lo == 3'd7);
        cnt_d  = cnt_q + 9'd1;
        if (cnt_q == 9'd511) begin
          state_d     = S_DRAIN;
          acc_d       = '0;
          out_valid_d = 1'b1;
          out_last_d  = 1'b0;
          out_pixel_d = pix_ram[0];
        end
      end
      S_DRAIN: begin
        if (io.out_ready) begin
          if (cnt_q[5:0] == 6'd63) begin
            state_d     = S_LOAD;
            cnt_d       = '0;
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            busy_d      = 1'b0;
            in_ready_d  = 1'b1;
            out_pixel_d = '0;
          end else begin
            cnt_d       = cnt_q + 9'd1;
            out_pixel_d = pix_ram[cnt_q[5:0] + 6'd1];
            out_last_d  = (cnt_q[5:0] == 6'd62);
          end
        end
      end
      default: state_d = S_LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_LOAD;
      cnt_q       <= '0;
      acc_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      out_pixel_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      busy_q      <= busy_d;
      out_pixel_q <= out_pixel_d;
    end
  end

  always_ff @(posedge clk) begin
    if (coef_we) coef_ram[cnt_q[5:0]] <= io.in_coef;
    if (t_we)    t_ram[{c_hi, c_mid}] <= t_val;
    if (pix_we)  pix_ram[{c_hi, c_mid}] <= pix_val;
  end

  assign io.in_ready  = in_ready_q;
  assign io.out_valid = out_valid_q;
  assign io.out_last  = out_last_q;
  assign io.out_pixel = out_pixel_q;
  assign busy         = busy_q;
endmodule

// File: tb/tb_idct_8x8_serial.sv
// Directed self-checking bench for idct_8x8_serial (honours IDCT_LEVEL_SHIFT_EN when defined).
module tb_idct_8x8_serial;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic busy;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  idct_8x8_serial_if #(.COEF_W(16), .PIX_W(16)) io ();

  idct_8x8_serial #(.COEF_W(16), .PIX_W(16)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .io   (io),
    .busy (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

`ifdef IDCT_LEVEL_SHIFT_EN
  localparam logic [15:0] EXP_DC = 16'd255, EXP_ZERO = 16'd128, EXP_NEG = 16'd0, EXP_SAT = 16'd255;
  localparam int AC_OFF = 128;
`else
  localparam logic [15:0] EXP_DC = 16'd128, EXP_ZERO = 16'd0, EXP_NEG = 16'hFF80, EXP_SAT = 16'd32767;
  localparam int AC_OFF = 0;
`endif

  logic signed [15:0] blk [64];
  logic [15:0] pix [64];
  logic        last_v [64];
  int acc_cyc, first_cyc, got_n, stable_err, inrdy_err, send_err;

  task automatic set_block(input logic signed [15:0] dc, input logic signed [15:0] rest,
                           input int idx, input logic signed [15:0] v);
    for (int i = 0; i < 64; i++) blk[i] = rest;
    blk[0] = dc;
    if (idx >= 0) blk[idx] = v;
  endtask

  // Leaves in_valid high after the 64th acceptance; caller decides what follows.
  task automatic send_block();
    int guard;
    send_err = 0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      io.in_valid = 1'b1;
      io.in_coef  = blk[i];
      guard = 0;
      while (!io.in_ready && guard < 50) begin
        @(negedge clk);
        guard++;
      end
      if (!io.in_ready) send_err++;
      acc_cyc = cyc;
    end
  endtask

  task automatic collect(input bit bp);
    int guard, j;
    logic rdy, prev_stall;
    logic [15:0] prev_pix;
    got_n = 0; first_cyc = -1; stable_err = 0; inrdy_err = 0;
    guard = 0; j = 0; prev_stall = 1'b0; prev_pix = '0;
    while (got_n < 64 && guard < 3000) begin
      @(negedge clk);
      guard++;
      if (io.in_ready) inrdy_err++;
      if (io.out_valid) begin
        if (first_cyc < 0) first_cyc = cyc;
        if (prev_stall && io.out_pixel !== prev_pix) stable_err++;
        rdy = bp ? ((j % 4) == 0 || (j % 4) == 3) : 1'b1;
        j++;
        io.out_ready = rdy;
        if (rdy) begin
          pix[got_n]    = io.out_pixel;
          last_v[got_n] = io.out_last;
          got_n++;
        end
        prev_stall = !rdy;
        prev_pix   = io.out_pixel;
      end else begin
        if (prev_stall) stable_err++;
        io.out_ready = 1'b0;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if (io.in_ready !== 1'b1)   begin n_bad++; $display("FAIL rst_in_ready: got %b expected 1", io.in_ready); end
    n_cmp++; if (io.out_valid !== 1'b0)  begin n_bad++; $display("FAIL rst_out_valid: got %b expected 0", io.out_valid); end
    n_cmp++; if (io.out_last !== 1'b0)   begin n_bad++; $display("FAIL rst_out_last: got %b expected 0", io.out_last); end
    n_cmp++; if (busy !== 1'b0)          begin n_bad++; $display("FAIL rst_busy: got %b expected 0", busy); end
    n_cmp++; if (io.out_pixel !== 16'd0) begin n_bad++; $display("FAIL rst_out_pixel: got %0d expected 0", io.out_pixel); end
    rst_n = 1'b1;
  endtask

  task automatic test_dc(input string nm, input logic signed [15:0] dc, input logic [15:0] exp_v);
    int bad, idx, bad_last;
    set_block(dc, 16'sd0, -1, 16'sd0);
    send_block();
    @(negedge clk);
    io.in_valid = 1'b0;
    n_cmp++; if (send_err !== 0)       begin n_bad++; $display("FAIL %s_accept: stalls %0d expected 0", nm, send_err); end
    n_cmp++; if (io.in_ready !== 1'b0) begin n_bad++; $display("FAIL %s_in_ready_drop: got %b expected 0", nm, io.in_ready); end
    n_cmp++; if (busy !== 1'b1)        begin n_bad++; $display("FAIL %s_busy_rise: got %b expected 1", nm, busy); end
    collect(1'b0);
    n_cmp++; if (got_n !== 64) begin n_bad++; $display("FAIL %s_count: got %0d expected 64", nm, got_n); end
    n_cmp++; if (first_cyc - acc_cyc !== 1025) begin n_bad++; $display("FAIL %s_latency: got %0d expected 1025", nm, first_cyc - acc_cyc); end
    bad = 0; idx = 0; bad_last = 0;
    for (int i = 0; i < got_n; i++) begin
      if (pix[i] !== exp_v) begin if (bad == 0) idx = i; bad++; end
      if (last_v[i] !== (i == 63)) bad_last++;
    end
    n_cmp++; if (bad !== 0) begin n_bad++; $display("FAIL %s_pixels: pixel[%0d]=%0d expected %0d (%0d wrong)", nm, idx, pix[idx], exp_v, bad); end
    n_cmp++; if (bad_last !== 0) begin n_bad++; $display("FAIL %s_out_last: %0d beats wrong expected 0", nm, bad_last); end
    @(negedge clk);
    io.out_ready = 1'b0;
    n_cmp++; if ({io.out_valid, busy, io.in_ready} !== 3'b001) begin n_bad++; $display("FAIL %s_post_drain: valid/busy/ready got %b expected 001", nm, {io.out_valid, busy, io.in_ready}); end
  endtask

  task automatic test_ac();
    int row [8] = '{44, 37, 25, 9, -9, -25, -37, -44};
    int bad, idx;
    logic [15:0] ev;
    set_block(16'sd0, 16'sd0, 1, 16'sd256);
    send_block();
    @(negedge clk);
    io.in_valid = 1'b0;
    collect(1'b0);
    n_cmp++; if (got_n !== 64) begin n_bad++; $display("FAIL ac_count: got %0d expected 64", got_n); end
    bad = 0; idx = 0;
    for (int i = 0; i < got_n; i++) begin
      ev = 16'(row[i % 8] + AC_OFF);
      if (pix[i] !== ev) begin if (bad == 0) idx = i; bad++; end
    end
    ev = 16'(row[idx % 8] + AC_OFF);
    n_cmp++; if (bad !== 0) begin n_bad++; $display("FAIL ac_pixels: pixel[%0d]=%0d expected %0d (%0d wrong)", idx, $signed(pix[idx]), $signed(ev), bad); end
    @(negedge clk);
    io.out_ready = 1'b0;
  endtask

  task automatic test_saturate();
    set_block(16'sd32767, 16'sd32767, -1, 16'sd0);
    send_block();
    @(negedge clk);
    io.in_valid = 1'b0;
    collect(1'b0);
    n_cmp++; if (got_n !== 64) begin n_bad++; $display("FAIL sat_count: got %0d expected 64", got_n); end
    n_cmp++; if (pix[0] !== EXP_SAT) begin n_bad++; $display("FAIL sat_pixel0: got %0d expected %0d", pix[0], EXP_SAT); end
    @(negedge clk);
    io.out_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    int bad, idx;
    set_block(-16'sd1024, 16'sd0, -1, 16'sd0);
    send_block();
    @(negedge clk);
    io.in_coef = 16'h1234;
    collect(1'b1);
    n_cmp++; if (got_n !== 64) begin n_bad++; $display("FAIL bp_count: got %0d expected 64", got_n); end
    bad = 0; idx = 0;
    for (int i = 0; i < got_n; i++) if (pix[i] !== EXP_NEG) begin if (bad == 0) idx = i; bad++; end
    n_cmp++; if (bad !== 0)        begin n_bad++; $display("FAIL bp_pixels: pixel[%0d]=%0d expected %0d (%0d wrong)", idx, pix[idx], EXP_NEG, bad); end
    n_cmp++; if (stable_err !== 0) begin n_bad++; $display("FAIL bp_hold: %0d unstable stalls expected 0", stable_err); end
    n_cmp++; if (inrdy_err !== 0)  begin n_bad++; $display("FAIL bp_in_ready: high %0d cycles expected 0", inrdy_err); end
    @(negedge clk);
    io.in_valid  = 1'b0;
    io.out_ready = 1'b0;
    n_cmp++; if ({io.out_valid, busy, io.in_ready} !== 3'b001) begin n_bad++; $display("FAIL bp_post_drain: valid/busy/ready got %b expected 001", {io.out_valid, busy, io.in_ready}); end
  endtask

  task automatic test_mid_reset();
    set_block(16'sd1024, 16'sd0, -1, 16'sd0);
    send_block();
    @(negedge clk);
    io.in_valid = 1'b0;
    while (cyc < acc_cyc + 300) @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_cmp++; if (busy !== 1'b0)        begin n_bad++; $display("FAIL mrst_busy: got %b expected 0", busy); end
    n_cmp++; if (io.out_valid !== 1'b0) begin n_bad++; $display("FAIL mrst_out_valid: got %b expected 0", io.out_valid); end
    n_cmp++; if (io.in_ready !== 1'b1) begin n_bad++; $display("FAIL mrst_in_ready: got %b expected 1", io.in_ready); end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    test_dc("mrst_dc", 16'sd1024, EXP_DC);
  endtask

  initial begin
    io.in_valid  = 1'b0;
    io.in_coef   = '0;
    io.out_ready = 1'b0;
    test_reset();
    test_dc("dc", 16'sd1024, EXP_DC);
    test_ac();
    test_saturate();
    test_backpressure();
    test_dc("zero", 16'sd0, EXP_ZERO);
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
